// File: rtl/button_debounce_if.sv
// Push-button strobe bundle: raw key pin in, debounced level and control strobes out.
// The debouncer drives it through master; consumers (LED blinker, timer) attach as slave.
interface button_debounce_if;
    logic key_in;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;
    logic toggle_state;

    modport master (
        input  key_in,
        output key_level,
        output press_pulse,
        output release_pulse,
        output long_press_pulse,
        output toggle_state
    );

    modport slave (
        output key_in,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press_pulse,
        input  toggle_state
    );
endinterface

// File: rtl/button_debounce.sv
// Debounces a raw asynchronous push-button into a clean level and registered
// one-cycle press / release / long-press strobes plus a press-toggled state bit.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    button_debounce_if.master btn
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [31:0] DB_TERM   = DEBOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] HOLD_TERM = LONG_PRESS_CYCLES - 32'd1;

    state_t      state;
    state_t      state_nxt;

    logic        key_raw;
    logic        key_sync_p0;
    logic        key_sync_p1;
    logic        sync;

    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic [31:0] hold_cnt;
    logic [31:0] hold_cnt_nxt;
    logic        long_done;
    logic        long_done_nxt;
    logic        db_done;

    logic        key_level;
    logic        key_level_nxt;
    logic        toggle_state;
    logic        toggle_state_nxt;
    logic        press_pulse;
    logic        press_pulse_nxt;
    logic        release_pulse;
    logic        release_pulse_nxt;
    logic        long_press_pulse;
    logic        long_press_pulse_nxt;

    // Normalise polarity so the rest of the block always treats 1 as pressed.
    assign key_raw = btn.key_in ^ ACTIVE_LOW;

    // Stage p0 -> p1: two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            key_sync_p0 <= 1'b0;
            key_sync_p1 <= 1'b0;
        end else begin
            key_sync_p0 <= key_raw;
            key_sync_p1 <= key_sync_p0;
        end
    end

    assign sync    = key_sync_p1;
    assign db_done = (cnt == DB_TERM);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sync) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sync)        state_nxt = IDLE;
                else if (db_done) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (!sync) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sync)         state_nxt = PRESSED;
                else if (db_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt              = cnt;
        hold_cnt_nxt         = hold_cnt;
        long_done_nxt        = long_done;
        key_level_nxt        = key_level;
        toggle_state_nxt     = toggle_state;
        press_pulse_nxt      = 1'b0;
        release_pulse_nxt    = 1'b0;
        long_press_pulse_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (sync) cnt_nxt = 32'd0;
            end
            PRESS_WAIT: begin
                if (sync) begin
                    if (db_done) begin
                        key_level_nxt    = 1'b1;
                        press_pulse_nxt  = 1'b1;
                        toggle_state_nxt = ~toggle_state;
                        hold_cnt_nxt     = 32'd0;
                        long_done_nxt    = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
            end
            PRESSED: begin
                if (!sync) cnt_nxt = 32'd0;
            end
            RELEASE_WAIT: begin
                if (!sync) begin
                    if (db_done) begin
                        key_level_nxt     = 1'b0;
                        release_pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
            end
            default: ;
        endcase

        // Hold timer runs through release bounces; an accepted release pre-empts the long-press strobe.
        if ((state == PRESSED || state == RELEASE_WAIT) && !release_pulse_nxt && !long_done) begin
            if (hold_cnt == HOLD_TERM) begin
                long_press_pulse_nxt = 1'b1;
                long_done_nxt        = 1'b1;
            end else begin
                hold_cnt_nxt = hold_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt              <= 32'd0;
            hold_cnt         <= 32'd0;
            long_done        <= 1'b0;
            key_level        <= 1'b0;
            toggle_state     <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            cnt              <= cnt_nxt;
            hold_cnt         <= hold_cnt_nxt;
            long_done        <= long_done_nxt;
            key_level        <= key_level_nxt;
            toggle_state     <= toggle_state_nxt;
            press_pulse      <= press_pulse_nxt;
            release_pulse    <= release_pulse_nxt;
            long_press_pulse <= long_press_pulse_nxt;
        end
    end

    assign btn.key_level        = key_level;
    assign btn.press_pulse      = press_pulse;
    assign btn.release_pulse    = release_pulse;
    assign btn.long_press_pulse = long_press_pulse;
    assign btn.toggle_state     = toggle_state;

    a_press_release_exclusive : assert property (
        @(posedge sys_clk) disable iff (!rst_n) !(press_pulse && release_pulse)
    );

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, active-low key.
module tb_button_debounce;

    logic sys_clk = 1'b0;
    logic rst_n;

    button_debounce_if bif ();

    button_debounce #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .btn    (bif)
    );

    always #5 sys_clk = ~sys_clk;

    // exp packs {key_level, press_pulse, release_pulse, long_press_pulse, toggle_state}
    typedef struct {
        logic       key;
        logic       rst;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input int n, input logic k, input logic r, input logic l,
                                input logic p, input logic rl, input logic lg, input logic t);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.key = k;
            v.rst = r;
            v.exp = {l, p, rl, lg, t};
            vecs.push_back(v);
        end
    endfunction

    function automatic logic [4:0] outs();
        return {bif.key_level, bif.press_pulse, bif.release_pulse, bif.long_press_pulse, bif.toggle_state};
    endfunction

    task automatic step(input logic k, input logic r);
        bif.key_in = k;
        rst_n      = r;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b (level,press,release,long,toggle)", name, idx, got, exp);
        end
    endtask

    task automatic chk_n(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        logic [4:0] o;
        int n_press;
        int n_rel;
        int n_long;

        bif.key_in = 1'b1;
        rst_n      = 1'b0;

        // reset state
        add(2, 1, 0, 0, 0, 0, 0, 0);
        // clean press: pulse after edge 6, long after edge 16
        add(6, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 0, 0, 1);
        add(9, 0, 1, 1, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 0, 1, 1);
        add(3, 0, 1, 1, 0, 0, 0, 1);
        // release, one-cycle glitch seen at count 2, then stable release
        add(3, 1, 1, 1, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 0, 0, 1);
        add(6, 1, 1, 1, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 1, 0, 1);
        add(3, 1, 1, 0, 0, 0, 0, 1);
        // bounce: 2 low / 2 high for 20 cycles, then released
        for (int b = 0; b < 5; b++) begin
            add(2, 0, 1, 0, 0, 0, 0, 1);
            add(2, 1, 1, 0, 0, 0, 0, 1);
        end
        add(6, 1, 1, 0, 0, 0, 0, 1);
        // reset, then two short presses separated by 8 released cycles
        add(2, 1, 0, 0, 0, 0, 0, 0);
        add(6, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0, 1);
        add(5, 1, 1, 1, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1);
        add(6, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 1, 1, 0, 0, 0);
        add(5, 1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 1, 0, 0);
        add(4, 1, 1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].key, vecs[i].rst);
            chk("vec", i, outs(), vecs[i].exp);
        end

        // release terminal lands on the hold terminal edge: release wins
        n_press = 0;
        n_rel   = 0;
        n_long  = 0;
        for (int i = 0; i < 26; i++) begin
            step((i < 10) ? 1'b0 : 1'b1, 1'b1);
            o = outs();
            if (o[3]) n_press++;
            if (o[2]) n_rel++;
            if (o[1]) n_long++;
            if (i == 6)  chk("coin_press", i, o, 5'b11001);
            if (i == 15) chk("coin_hold", i, o, 5'b10001);
            if (i == 16) chk("coin_release", i, o, 5'b00101);
        end
        chk_n("coin_long_count", n_long, 0);
        chk_n("coin_press_count", n_press, 1);
        chk_n("coin_release_count", n_rel, 1);

        // reset while PRESS_WAIT holds cnt=2, key held throughout
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            if (i == 4) chk("mid_pre", i, outs(), 5'b00001);
        end
        step(1'b0, 1'b0);
        chk("mid_reset", 0, outs(), 5'b00000);
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 1'b1);
            if (j < 6)       chk("mid_wait", j, outs(), 5'b00000);
            else if (j == 6) chk("mid_press", j, outs(), 5'b11001);
            else             chk("mid_held", j, outs(), 5'b10001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
